sram_sync_be: RTL

- Parametrised synchronous SRAM model with byte-lane write enables, a configurable read-latency pipeline and programmable wait states.
- Successor to the asynchronous 16-bit/1K-entry SRAM model. Generalised in data width, depth and timing.
- Adds a clocked request/ready handshake, a read-valid strobe and out-of-range error reporting.
- Sits on the simplecore external memory bus as the memory behind the core's load/store and fetch paths.

---
 rtl/sram_sync_be.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_sync_be.sv
// Synchronous SRAM model with byte-lane writes, a configurable read-latency
// pipeline, programmable wait states and out-of-range error strobes.
module sram_sync_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WAIT   = 0
) (
  input  logic                clk,
  input  logic                nRESET,
  input  logic                nCS,
  input  logic                nWE,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] nBE,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                err
);
  localparam int unsigned    LANES     = DATA_W / 8;
  localparam int unsigned    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]     WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [2:0]        wait_cnt;
  logic              out_v;
  logic              out_e;
  logic [DATA_W-1:0] out_d;

  always_comb begin
    accept   = nRESET && ready && !nCS;
    in_range = {1'b0, addr} < DEPTH_L;
    rd_acc   = accept && nWE;
    wr_acc   = accept && !nWE;
    idx      = addr[IDX_W-1:0];
    rd_word  = in_range ? mem[idx] : '0;
  end

  // Array is deliberately not reset; a write on a reset edge is never accepted.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!nBE[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ready drops for WAIT cycles after each accept; after reset the counter is
  // already zero, so ready comes up on the first released edge.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      ready    <= 1'b0;
      wait_cnt <= '0;
    end else if (!ready) begin
      if (wait_cnt == '0) ready <= 1'b1;
      else                wait_cnt <= wait_cnt - 3'd1;
    end else if (accept && (WAIT != 0)) begin
      ready    <= 1'b0;
      wait_cnt <= WAIT_LOAD;
    end
  end

  // The output register is the last pipeline stage, so only RD_LAT-1 stages sit before it.
  generate
    if (RD_LAT == 1) begin : g_direct
      always_comb begin
        out_v = rd_acc;
        out_e = rd_acc && !in_range;
        out_d = rd_word;
      end
    end else begin : g_pipe
      logic [RD_LAT-2:0] pv;
      logic [RD_LAT-2:0] pe;
      logic [DATA_W-1:0] pd [RD_LAT-1];

      always_ff @(posedge clk) begin
        if (!nRESET) begin
          pv <= '0;
          pe <= '0;
        end else begin
          pv[0] <= rd_acc;
          pe[0] <= rd_acc && !in_range;
          for (int unsigned k = 1; k < RD_LAT - 1; k++) begin
            pv[k] <= pv[k-1];
            pe[k] <= pe[k-1];
          end
        end
        pd[0] <= rd_word;
        for (int unsigned k = 1; k < RD_LAT - 1; k++) pd[k] <= pd[k-1];
      end

      always_comb begin
        out_v = pv[RD_LAT-2];
        out_e = pe[RD_LAT-2];
        out_d = pd[RD_LAT-2];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= out_v;
      err    <= (wr_acc && !in_range) || (out_v && out_e);
      if (out_v) rdata <= out_d;
    end
  end

endmodule
